// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered single-cycle ops, iterative shift-add
// multiplier with double-width product, status flags and illegal-opcode reporting.
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOR = 4'h7;
  localparam logic [3:0] OP_SLL = 4'h8;
  localparam logic [3:0] OP_SRL = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_SWP = 4'hB;

  localparam int               HALF     = WIDTH / 2;
  localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   LAST_CNT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic [WIDTH-1:0]   lo_s;
  logic               c_s;
  logic               v_s;
  logic               err_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   rot_s;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] addend_s;
  logic [2*WIDTH-1:0] acc_nxt_s;
  logic [SHW-1:0]     cnt_r;

  assign accept_s  = in_valid && in_ready;
  assign addend_s  = mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}};
  assign acc_nxt_s = acc_r + addend_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (op == OP_MUL) ? S_MUL : S_DONE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_MUL;
        end
      end
      S_DONE: begin
        if (accept_s) begin
          state_nxt_s = (op == OP_MUL) ? S_MUL : S_DONE;
        end else if (out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = (state_r == S_IDLE) || ((state_r == S_DONE) && out_ready);
    out_valid = (state_r == S_DONE);
  end

  // Single-cycle operation results and flags
  always_comb begin
    lo_s   = {WIDTH{1'b0}};
    c_s    = 1'b0;
    v_s    = 1'b0;
    err_s  = 1'b0;
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
    rot_s  = b % W_VAL;
    case (op)
      OP_ADD: begin
        lo_s = sum_s[WIDTH-1:0];
        c_s  = sum_s[WIDTH];
        v_s  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        lo_s = diff_s[WIDTH-1:0];
        c_s  = diff_s[WIDTH];
        v_s  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: lo_s = {WIDTH{1'b0}};
      OP_AND: lo_s = a & b;
      OP_OR:  lo_s = a | b;
      OP_XOR: lo_s = a ^ b;
      OP_NOR: lo_s = ~(a | b);
      OP_SLL: begin
        if (b >= W_VAL) begin
          lo_s = {WIDTH{1'b0}};
        end else begin
          lo_s = a << b;
        end
      end
      OP_SRL: begin
        if (b >= W_VAL) begin
          lo_s = {WIDTH{1'b0}};
        end else begin
          lo_s = a >> b;
        end
      end
      OP_ROL: lo_s = (a << rot_s) | (a >> (W_VAL - rot_s));
      OP_SWP: lo_s = {a[HALF-1:0], a[WIDTH-1:HALF]};
      default: err_s = 1'b1;
    endcase
  end

  // Operand capture, multiplier iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      cnt_r     <= {SHW{1'b0}};
      result_lo <= {WIDTH{1'b0}};
      result_hi <= {WIDTH{1'b0}};
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_err  <= 1'b0;
    end else if (accept_s) begin
      if (op == OP_MUL) begin
        mcand_r  <= {{WIDTH{1'b0}}, a};
        mplier_r <= b;
        acc_r    <= {(2*WIDTH){1'b0}};
        cnt_r    <= {SHW{1'b0}};
      end else begin
        // Illegal ops leave lo_s at zero, which also raises flag_z
        result_lo <= lo_s;
        result_hi <= {WIDTH{1'b0}};
        flag_z    <= (lo_s == {WIDTH{1'b0}});
        flag_n    <= lo_s[WIDTH-1];
        flag_c    <= c_s;
        flag_v    <= v_s;
        flag_err  <= err_s;
      end
    end else if (state_r == S_MUL) begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + 1'b1;
      if (cnt_r == LAST_CNT) begin
        result_lo <= acc_nxt_s[WIDTH-1:0];
        result_hi <= acc_nxt_s[2*WIDTH-1:WIDTH];
        flag_z    <= (acc_nxt_s == {(2*WIDTH){1'b0}});
        flag_n    <= acc_nxt_s[2*WIDTH-1];
        flag_c    <= |acc_nxt_s[2*WIDTH-1:WIDTH];
        flag_v    <= 1'b0;
        flag_err  <= 1'b0;
      end else begin
        result_lo <= result_lo;
      end
    end else begin
      result_lo <= result_lo;
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 4-bit combinational ALU opcode set. It implements all constants-package opcodes at any even WIDTH.
- Adds registered results, status flags, an iterative shift-add multiplier producing a double-width product, and illegal-opcode detection.
- Sits between the CPU decode/issue stage and writeback. It accepts one operation at a time over a valid/ready handshake.

Parameters:
- WIDTH, 4, operand/result width in bits; must be even and >= 4.
- SHW, $clog2(WIDTH), derived, width of the internal shift-count and multiply iteration counter; not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  op/a/b valid
- in_ready  output  1  block can accept an operation this cycle
- op  input  4  opcode, encoding per constants package (0x0 ADD .. 0xB SWP)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result this cycle
- result_lo  output  WIDTH  result, or low half of MUL product
- result_hi  output  WIDTH  high half of MUL product; 0 for all other ops
- flag_z  output  1  result_lo == 0 (MUL: full product == 0)
- flag_n  output  1  result_lo[WIDTH-1] (MUL: result_hi[WIDTH-1])
- flag_c  output  1  carry/borrow/high-nonzero, see Behaviour
- flag_v  output  1  signed overflow for ADD/SUB, else 0
- flag_err  output  1  illegal opcode (0x3, 0xC-0xF)

Behaviour:
- State machine: IDLE, MUL, DONE.
- Reset (rst_n=0 at a clock edge): state IDLE; out_valid=0; result_lo=0; result_hi=0; all flags 0. Any in-flight MUL is discarded with no output.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 in MUL.
- Accept occurs when in_valid && in_ready. op, a and b are captured on the accept edge.
- Single-cycle ops (all except MUL):
  - The result is registered on the accept edge; state goes to DONE.
  - out_valid=1 the next cycle, so latency is 1.
- MUL:
  - The accept edge loads the multiplicand, multiplier and a zeroed accumulator, and sets the counter to 0; state goes to MUL.
  - Each MUL cycle performs one shift-add step.
  - After WIDTH steps the product is registered and state goes to DONE.
  - out_valid rises WIDTH+1 cycles after accept.
- DONE:
  - out_valid=1. Outputs are held stable until out_ready=1.
  - On out_valid && out_ready with a simultaneous accept, the next op is taken: back-to-back throughput is 1 op/cycle for single-cycle ops.
  - Without a new accept, state returns to IDLE and out_valid falls.
- Arithmetic (unsigned modulo 2^WIDTH unless stated):
  - ADD: {c,lo}=a+b; v=(a[msb]==b[msb])&&(lo[msb]!=a[msb]).
  - SUB: lo=a-b; c=1 iff a<b (borrow); v=(a[msb]!=b[msb])&&(lo[msb]!=a[msb]).
  - MUL: {hi,lo}=a*b unsigned; c=(hi!=0).
  - AND/OR/XOR/NOR: bitwise.
  - SLL/SRL: logical shift of a by b; if b>=WIDTH, lo=0.
  - ROL: rotate a left by (b mod WIDTH).
  - SWP: lo={a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]}; b ignored.
  - flag_c and flag_v are 0 for every op not listed above.
  - result_hi is 0 for every op except MUL.
- Illegal opcode:
  - Accepted normally with latency 1.
  - Response: result_lo=result_hi=0, flag_err=1, flag_z=1, other flags 0.
  - flag_err=0 for all legal ops.
- in_valid while in_ready=0: no effect. The source must hold its inputs until accepted.
- out_ready while out_valid=0: ignored.

Test Plan:
- WIDTH=4, ADD a=0x9 b=0x8 -> 1 cycle later result_lo=0x1, hi=0, c=1, v=1, z=0, n=0.
- WIDTH=4, SUB a=0x3 b=0x5 -> result_lo=0xE, c=1, n=1, v=0. Then SUB a=0x5 b=0x5 -> lo=0, z=1, c=0.
- WIDTH=4, MUL a=0xF b=0xF -> in_ready=0 for 4 cycles; out_valid 5 cycles after accept; hi=0xE, lo=0x1, c=1, n=1.
- WIDTH=8:
  - SWP a=0xA5 -> lo=0x5A.
  - ROL a=0x81 b=9 -> lo=0x03.
  - SLL a=0xFF b=8 -> lo=0x00, z=1.
  - op=0x3, then op=0xF -> err=1, lo=0.
- Backpressure: hold out_ready=0 for 3 cycles after an AND result -> outputs and out_valid stable, in_ready=0. Raising out_ready with in_valid=1 (XOR) -> XOR result valid the next cycle, no bubble.
- Reset mid-MUL: drop rst_n at cycle 2 of a WIDTH=4 MUL -> next cycle out_valid=0, in_ready=1, outputs 0. A following ADD 0x1+0x1 -> lo=0x2.
